// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues one outstanding imem request at a
// time, presents a single fetched instruction to IF/ID and squashes wrong-path
// fetches when execute redirects the PC.
module fetch_unit #(
    parameter int unsigned       WIDTH    = 32,
    parameter logic [WIDTH-1:0]  RESET_PC = '0,
    parameter int unsigned       PC_STEP  = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             stall_f,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             valid_f,
    output logic [WIDTH-1:0] instr_f,
    output logic [WIDTH-1:0] pc_f,
    output logic [WIDTH-1:0] pc_plus_f
);

    localparam logic [WIDTH-1:0] STEP       = WIDTH'(PC_STEP);
    localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] pc_plus_q, pc_plus_d;
    logic [WIDTH-1:0] instr_q, instr_d;
    logic             drop_q, drop_d;
    logic             req_q, valid_q;
    logic [WIDTH-1:0] redirect_target;

    // Redirect targets are always word aligned.
    assign redirect_target = redirect_pc & ALIGN_MASK;

    // Next-state and next-PC selection; redirect outranks every other event.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_plus_d = pc_plus_q;
        instr_d   = instr_q;
        drop_d    = drop_q;
        case (state_q)
            BOOT: begin
                state_d = REQ;
            end
            REQ: begin
                if (redirect_valid) begin
                    pc_d      = redirect_target;
                    pc_plus_d = redirect_target + STEP;
                    if (imem_gnt) begin
                        drop_d  = 1'b1;
                        state_d = WAIT;
                    end
                end else if (imem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_d      = redirect_target;
                    pc_plus_d = redirect_target + STEP;
                    if (imem_rvalid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d      = redirect_target;
                    pc_plus_d = redirect_target + STEP;
                    state_d   = REQ;
                end else if (!stall_f) begin
                    pc_d      = pc_plus_q;
                    pc_plus_d = pc_plus_q + STEP;
                    state_d   = REQ;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State, PC and buffered instruction; request/valid flags registered from next state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= BOOT;
            pc_q      <= RESET_PC;
            pc_plus_q <= RESET_PC + STEP;
            instr_q   <= '0;
            drop_q    <= 1'b0;
            req_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_plus_q <= pc_plus_d;
            instr_q   <= instr_d;
            drop_q    <= drop_d;
            req_q     <= (state_d == REQ);
            valid_q   <= (state_d == HOLD);
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign valid_f   = valid_q;
    assign instr_f   = instr_q;
    assign pc_f      = pc_q;
    assign pc_plus_f = pc_plus_q;

endmodule
